// File: rtl/frogger_pkg.sv
// Shared lane geometry, timing constants and direction type for the river pads.
// Constants only; no latency or flow-control behaviour of its own.
package frogger_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int NUM_LANES = 4;
    localparam int STEP      = 40;
    localparam int SCREEN_W  = 640;
    localparam int PAD_W     = 80;
    localparam int FROG_W    = 40;
    localparam int MIN_SPEED = 4;

    localparam logic [0:3][10:0] LANE_Y       = {11'd80, 11'd120, 11'd160, 11'd200};
    localparam logic [0:3][5:0]  BASE_SPEED   = {6'd30, 6'd24, 6'd36, 6'd20};
    localparam logic [0:3]       LANE_DIR     = 4'b0101;
    localparam logic [0:3][10:0] LANE_X_START = {11'd0, 11'd160, 11'd320, 11'd480};

    // Frames per step at a level; compare before subtracting so it cannot underflow.
    function automatic logic [5:0] lane_speed(input logic [5:0] base, input logic [2:0] level);
        logic [6:0] dec;
        dec = {2'b00, level, 2'b00};
        if ({1'b0, base} >= dec + 7'(MIN_SPEED)) begin
            return base - dec[5:0];
        end
        return 6'(MIN_SPEED);
    endfunction

endpackage

// File: rtl/lpad_lane.sv
// One pad lane: frame counter, wrapping stepper and frog-on-pad compare.
// All outputs registered, one frame latency; no backpressure, holds while run is low.
module lpad_lane
    import frogger_pkg::*;
#(
    parameter logic [10:0] Y       = 11'd80,
    parameter logic [10:0] X_START = 11'd0,
    parameter dir_t        DIR     = DIR_LEFT
) (
    input  logic        frame_clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  speed,
    input  logic [10:0] frog_x,
    input  logic [10:0] frog_y,
    output logic [10:0] x,
    output logic [5:0]  cnt,
    output logic        collision
);

    localparam logic [10:0] STEP_V  = 11'(STEP);
    localparam logic [10:0] WRAP_V  = 11'(SCREEN_W);
    localparam logic [10:0] PAD_V   = 11'(PAD_W);
    localparam logic [10:0] FROG_V  = 11'(FROG_W);

    logic [10:0] x_q, x_d, x_next;
    logic [5:0]  cnt_q, cnt_d;
    logic        col_q, col_d;
    logic [10:0] frog_right, pad_right;

    always_comb begin
        x_next = x_q;
        if (DIR == DIR_RIGHT) begin
            x_next = (x_q + STEP_V >= WRAP_V) ? x_q + STEP_V - WRAP_V : x_q + STEP_V;
        end else begin
            x_next = (x_q < STEP_V) ? x_q + WRAP_V - STEP_V : x_q - STEP_V;
        end

        x_d   = x_q;
        cnt_d = cnt_q;
        if (run) begin
            // >= also catches a count left above a speed that just dropped
            if (cnt_q >= speed - 6'd1) begin
                cnt_d = 6'd0;
                x_d   = x_next;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end

        frog_right = frog_x + FROG_V;
        pad_right  = x_q + PAD_V;
        col_d      = (frog_y == Y) && (frog_x >= x_q) && (frog_right <= pad_right);
    end

    always_ff @(posedge frame_clk) begin
        if (!rst_n) begin
            x_q   <= X_START;
            cnt_q <= 6'd0;
            col_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            cnt_q <= cnt_d;
            col_q <= col_d;
        end
    end

    assign x         = x_q;
    assign cnt       = cnt_q;
    assign collision = col_q;

endmodule

// File: rtl/lilypad_lanes.sv
// Four river pad lanes plus the difficulty level and per-lane speed registers.
// Outputs registered, one frame latency; no backpressure, Run=0 freezes pad motion.
module lilypad_lanes
    import frogger_pkg::*;
(
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Level_Up,
    input  logic [10:0]       FrogX,
    input  logic [10:0]       FrogY,
    output logic [0:3][10:0]  LPad_X,
    output logic [0:3][10:0]  LPad_Y,
    output logic [0:3][5:0]   LPad_Speed,
    output logic [3:0][5:0]   LPad_Remainder_Count,
    output logic [0:3]        LPad_Direction,
    output logic [3:0]        LPad_Collision,
    output logic [2:0]        Level
);

    logic [2:0]      level_q, level_d;
    logic [0:3][5:0] speed_q, speed_d;

    // Speed registers follow level_d so a new level lands on the same edge as
    // the level itself; lanes stepping on that edge still see the old speed.
    always_comb begin
        level_d = level_q;
        if (Level_Up && level_q != 3'd7) begin
            level_d = level_q + 3'd1;
        end
        speed_d = speed_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            speed_d[i] = lane_speed(BASE_SPEED[i], level_d);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            level_q <= 3'd0;
            speed_q <= BASE_SPEED;
        end else begin
            level_q <= level_d;
            speed_q <= speed_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lpad_lane #(
            .Y       (LANE_Y[g]),
            .X_START (LANE_X_START[g]),
            .DIR     (dir_t'(LANE_DIR[g]))
        ) u_lane (
            .frame_clk (frame_clk),
            .rst_n     (Reset),
            .run       (Run),
            .speed     (speed_q[g]),
            .frog_x    (FrogX),
            .frog_y    (FrogY),
            .x         (LPad_X[g]),
            .cnt       (LPad_Remainder_Count[g]),
            .collision (LPad_Collision[g])
        );
        assign LPad_Y[g]         = LANE_Y[g];
        assign LPad_Direction[g] = LANE_DIR[g];
    end

    assign LPad_Speed = speed_q;
    assign Level      = level_q;

endmodule

// File: tb/tb_lilypad_lanes.sv
// Bench for lilypad_lanes: frame-level lane model checked every frame plus pinned literals.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_lilypad_lanes;

    logic             frame_clk = 1'b0;
    logic             Reset, Run, Level_Up;
    logic [10:0]      FrogX, FrogY;
    logic [0:3][10:0] LPad_X, LPad_Y;
    logic [0:3][5:0]  LPad_Speed;
    logic [3:0][5:0]  LPad_Remainder_Count;
    logic [0:3]       LPad_Direction;
    logic [3:0]       LPad_Collision;
    logic [2:0]       Level;

    lilypad_lanes dut (
        .frame_clk            (frame_clk),
        .Reset                (Reset),
        .Run                  (Run),
        .Level_Up             (Level_Up),
        .FrogX                (FrogX),
        .FrogY                (FrogY),
        .LPad_X               (LPad_X),
        .LPad_Y               (LPad_Y),
        .LPad_Speed           (LPad_Speed),
        .LPad_Remainder_Count (LPad_Remainder_Count),
        .LPad_Direction       (LPad_Direction),
        .LPad_Collision       (LPad_Collision),
        .Level                (Level)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    // Model: pad position, frames since last step, level, speed, collision
    int m_y[4]     = '{80, 120, 160, 200};
    int m_base[4]  = '{30, 24, 36, 20};
    int m_dir[4]   = '{0, 1, 0, 1};
    int m_start[4] = '{0, 160, 320, 480};
    int m_x[4], m_cnt[4], m_spd[4], m_col[4];
    int m_lvl;

    function automatic int spd_of(input int base, input int lvl);
        int s;
        s = base - 4 * lvl;
        return (s < 4) ? 4 : s;
    endfunction

    always @(posedge frame_clk) begin
        if (!Reset) begin
            m_lvl = 0;
            for (int i = 0; i < 4; i++) begin
                m_x[i] = m_start[i]; m_cnt[i] = 0; m_col[i] = 0; m_spd[i] = m_base[i];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_col[i] = (int'(FrogY) == m_y[i]) && (int'(FrogX) >= m_x[i]) &&
                           (((int'(FrogX) + 40) % 2048) <= m_x[i] + 80) ? 1 : 0;
                if (Run) begin
                    if (m_cnt[i] + 1 >= m_spd[i]) begin
                        m_cnt[i] = 0;
                        m_x[i] = m_dir[i] ? (m_x[i] + 40) % 640 : (m_x[i] + 600) % 640;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            if (Level_Up && m_lvl < 7) m_lvl = m_lvl + 1;
            for (int i = 0; i < 4; i++) m_spd[i] = spd_of(m_base[i], m_lvl);
        end
        #1;
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk("x", i, int'(LPad_X[i]), m_x[i]);
                chk("cnt", i, int'(LPad_Remainder_Count[i]), m_cnt[i]);
                chk("speed", i, int'(LPad_Speed[i]), m_spd[i]);
                chk("col", i, int'(LPad_Collision[i]), m_col[i]);
                chk("y", i, int'(LPad_Y[i]), m_y[i]);
                chk("dir", i, int'(LPad_Direction[i]), m_dir[i]);
            end
            chk("level", 0, int'(Level), m_lvl);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        edges(1);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; Level_Up = 1'b0; FrogX = 11'd0; FrogY = 11'd0;
        edges(2);
        chk_en = 1'b1;
        chk("rst_x", 0, int'(LPad_X[0]), 0);
        chk("rst_x", 1, int'(LPad_X[1]), 160);
        chk("rst_speed", 2, int'(LPad_Speed[2]), 36);
        chk("rst_col", 0, int'(LPad_Collision), 0);
        chk("rst_level", 0, int'(Level), 0);

        // Free run: lane 1 steps at edge 24, lane 0 wraps left at edge 30
        Reset = 1'b1; Run = 1'b1;
        edges(23);
        chk("lane1_pre", 1, int'(LPad_X[1]), 160);
        edges(1);
        chk("lane1_step", 1, int'(LPad_X[1]), 200);
        edges(6);
        chk("lane0_wrap", 0, int'(LPad_X[0]), 600);
        chk("lane0_cnt", 0, int'(LPad_Remainder_Count[0]), 0);

        // Pause holds positions and counts
        do_reset();
        Run = 1'b1;
        edges(10);
        Run = 1'b0;
        edges(50);
        chk("pause_x", 0, int'(LPad_X[0]), 0);
        chk("pause_cnt", 0, int'(LPad_Remainder_Count[0]), 10);
        chk("pause_cnt", 3, int'(LPad_Remainder_Count[3]), 10);
        chk("pause_x", 3, int'(LPad_X[3]), 480);

        // Right wrap on lane 3, left wrap on lane 2
        do_reset();
        Run = 1'b1;
        edges(60);
        chk("lane3_600", 3, int'(LPad_X[3]), 600);
        edges(20);
        chk("lane3_wrap", 3, int'(LPad_X[3]), 0);
        edges(250);
        chk("lane2_wrap", 2, int'(LPad_X[2]), 600);

        // Level saturation and speed floor
        do_reset();
        Run = 1'b1;
        for (int k = 0; k < 9; k++) begin
            Level_Up = 1'b1;
            edges(1);
            Level_Up = 1'b0;
            edges(1);
        end
        chk("lvl_sat", 0, int'(Level), 7);
        chk("lvl_speed", 0, int'(LPad_Speed[0]), 4);
        chk("lvl_speed", 1, int'(LPad_Speed[1]), 4);
        chk("lvl_speed", 2, int'(LPad_Speed[2]), 8);
        chk("lvl_speed", 3, int'(LPad_Speed[3]), 4);
        edges(40);

        // Mid-count reset restores start state; Reset beats Level_Up
        Reset = 1'b0; Level_Up = 1'b1;
        edges(1);
        Reset = 1'b1; Level_Up = 1'b0; Run = 1'b0;
        chk("midrst_x", 1, int'(LPad_X[1]), 160);
        chk("midrst_lvl", 0, int'(Level), 0);

        // Collision boundaries on lane 1 (X=160)
        FrogY = 11'd120; FrogX = 11'd200;
        edges(1);
        chk("col_edge", 1, int'(LPad_Collision), 2);
        FrogX = 11'd201;
        edges(1);
        chk("col_over", 1, int'(LPad_Collision), 0);
        FrogX = 11'd160;
        edges(1);
        chk("col_left", 1, int'(LPad_Collision), 2);
        FrogX = 11'd159;
        edges(1);
        chk("col_under", 1, int'(LPad_Collision), 0);
        FrogX = 11'd200; FrogY = 11'd121;
        edges(1);
        chk("col_y", 1, int'(LPad_Collision), 0);
        FrogX = 11'd0; FrogY = 11'd80;
        edges(1);
        chk("col_lane0", 0, int'(LPad_Collision), 1);
        FrogX = 11'd630;
        Run = 1'b1;
        edges(40);
        FrogX = 11'd200; FrogY = 11'd120;
        edges(40);

        // Level_Up at cnt=25 drops speed below the count: step next edge
        do_reset();
        Run = 1'b1; FrogX = 11'd0; FrogY = 11'd0;
        edges(25);
        chk("lu_cnt", 0, int'(LPad_Remainder_Count[0]), 25);
        Level_Up = 1'b1;
        edges(1);
        Level_Up = 1'b0;
        chk("lu_cnt26", 0, int'(LPad_Remainder_Count[0]), 26);
        chk("lu_speed", 0, int'(LPad_Speed[0]), 26);
        chk("lu_x_hold", 0, int'(LPad_X[0]), 0);
        edges(1);
        chk("lu_step", 0, int'(LPad_X[0]), 600);
        chk("lu_cnt0", 0, int'(LPad_Remainder_Count[0]), 0);
        edges(30);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lilypad_lanes.md
# lilypad_lanes

Generates and animates the four lily-pad lanes of the river region. Each lane holds one pad that steps a fixed distance every N frames in a fixed direction, wrapping across the screen. The block produces the per-lane speed, phase, direction and frog-on-pad collision that the frog controller consumes to ride pads. It also produces pad positions for the sprite/colour mapper.

## Interface
- NUM_LANES, 4: number of pad lanes; fixed at 4.
- STEP, 40: pixels per pad step.
- SCREEN_W, 640: horizontal wrap modulus.
- PAD_W, 80: pad width in pixels.
- FROG_W, 40: frog width used for the on-pad test.
- MIN_SPEED, 4: fastest allowed frames-per-step.
- frame_clk  in  1  frame-rate clock (one edge per VGA frame).
- Reset  in  1  synchronous, active-low: Reset==0 sampled on a frame_clk edge resets the block.
- Run  in  1  1 = lanes animate, 0 = paused (positions and phases hold).
- Level_Up  in  1  single-frame pulse on frog win; raises difficulty.
- FrogX, FrogY  in  11 each  frog top-left pixel.
- LPad_X  out  [0:3][10:0]  pad left edge per lane, 0..SCREEN_W-1.
- LPad_Y  out  [0:3][10:0]  pad top edge per lane (constant).
- LPad_Speed  out  [0:3][5:0]  frames per step, current level.
- LPad_Remainder_Count  out  [3:0][5:0]  frames elapsed since that lane's last step.
- LPad_Direction  out  [0:3]  0 = left, 1 = right.
- LPad_Collision  out  [3:0]  frog fully on pad i.
- Level  out  3  current difficulty, 0..7.

## Operation
- Lane constants: Y = 80, 120, 160, 200. Base speed = 30, 24, 36, 20. Direction = 0, 1, 0, 1. Start X = 0, 160, 320, 480.
- Speed: LPad_Speed[i] = max(BASE[i] − 4·Level, MIN_SPEED), in 6-bit unsigned. Compute it before subtracting so it never underflows.
- Per lane, when Run=1:
  - If cnt == speed−1, or cnt ≥ speed (speed just dropped): cnt ← 0 and X steps.
  - Otherwise cnt ← cnt+1.
- LPad_Remainder_Count[i] = cnt[i]; it is always in 0..speed−1 except in the one frame after a speed decrease.
- Left step: X ← (X < STEP) ? X + SCREEN_W − STEP : X − STEP.
- Right step: X ← (X + STEP ≥ SCREEN_W) ? X + STEP − SCREEN_W : X + STEP.
- Run=0: cnt and X hold. Collision and Level still update.
- Level: on Level_Up, Level ← Level+1, saturating at 7. The new speed applies from the next frame.
- Collision[i] is asserted when all of the following hold:
  - FrogY == LPad_Y[i]
  - FrogX ≥ LPad_X[i]
  - FrogX + FROG_W ≤ LPad_X[i] + PAD_W
- The collision test is unwrapped: a pad straddling the right edge reports collision only for its on-screen left segment. The comparison is 11-bit unsigned.
- At most one collision bit is set at a time, since the lanes have distinct Y.

## Timing
- All outputs are registered.
- Reset values: X = start values, cnt = 0, Level = 0, Collision = 0, Speed = base values, Direction and Y = constants.
- Step latency: X updates on the edge where cnt == speed−1 was held. The first step after reset therefore occurs on edge number speed.
- Collision latency: one frame. It uses the FrogX/FrogY and LPad_X registered at the previous edge. On a step frame, collision reflects the pre-step pad position.
- Level_Up and a lane step on the same edge: the step uses the old speed; the new speed applies to the next count.
- Reset overrides Run and Level_Up on the same edge.
- Reset asserted mid-count restores start positions with no partial step.

## Structure
- frogger_pkg holds:
  - lane constants: LANE_Y, BASE_SPEED, LANE_DIR, LANE_X_START arrays
  - STEP, SCREEN_W, PAD_W
  - a dir_t enum {DIR_LEFT=0, DIR_RIGHT=1}, shared with the frog controller
- Sub-module lpad_lane: one lane's counter, wrap-stepper and collision compare. It is parameterised by Y, start X and direction, and takes speed, Run and Frog position.
- The top instantiates four lpad_lane copies and holds the Level register and speed computation.

## Test plan
- Reset=0 for 2 edges, then Run=1 for 30 edges → LPad_X[0] = 600 (wrapped left), LPad_Remainder_Count[0] = 0; LPad_X[1] unchanged until edge 24, then 200.
- Run=1 for 10 edges, then Run=0 for 50 edges → all X and Remainder_Count frozen at their edge-10 values.
- Place lane 3 at X=600, moving right, and step → X=0. Place lane 2 at X=20, moving left, and step → X=620.
- Pulse Level_Up 9 times → Level=7. LPad_Speed = 4, 4, 8, 4, never wrapping below MIN_SPEED.
- FrogY=120, FrogX=LPad_X[1]+40 → LPad_Collision=4'b0010 one edge later. FrogX=LPad_X[1]+41 → 0. FrogY=121 → 0.
- Drive Level_Up while lane 0 has cnt=25 and speed drops 30→26 → step on the next edge, cnt=0, X decreases by 40.
